// File: rtl/vga_bus_pkg.sv
// rtl/vga_bus_pkg.sv - register map, status bit positions, command kinds and FSM states of the VGA bus master
package vga_bus_pkg;

    localparam logic [3:0] REG_MODE    = 4'd0;
    localparam logic [3:0] REG_INSTR   = 4'd1;
    localparam logic [3:0] REG_ARG0    = 4'd2;
    localparam logic [3:0] REG_STATUS  = 4'd13;
    localparam logic [3:0] REG_RESULT0 = 4'd14;
    localparam logic [3:0] REG_RESULT1 = 4'd15;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_FINISHED = 1;
    localparam int STAT_ERROR    = 2;
    localparam int STAT_FAULT    = 3;

    localparam logic CMD_INSTR = 1'b0;
    localparam logic CMD_MODE  = 1'b1;

    localparam logic [3:0] MAX_NARGS = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MODE,
        S_ARG,
        S_INSTR,
        S_POLL,
        S_RD0,
        S_RD1,
        S_RESP
    } state_t;

    function automatic logic is_bus_state(input state_t s);
        return !(s inside {S_IDLE, S_RESP});
    endfunction

    function automatic logic is_read_state(input state_t s);
        return s inside {S_POLL, S_RD0, S_RD1};
    endfunction

endpackage

// File: rtl/vga_bus_master_phi2_gen.sv
// rtl/vga_bus_master_phi2_gen.sv - PHI2 divider: low half then high half, with one-clk rise/fall/sample strobes
module phi2_gen #(
    parameter int PHI2_HALF = 12
) (
    input  logic clk,
    input  logic reset,
    output logic phi2,
    output logic rise_strobe,
    output logic fall_strobe,
    output logic sample_strobe
);
    localparam int CW = $clog2(2 * PHI2_HALF);
    localparam logic [CW-1:0] CNT_RISE = CW'(PHI2_HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * PHI2_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phi2_q, phi2_d;

    // Strobes are high during the clk whose closing edge moves phi2.
    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        phi2_d = phi2_q;
        if (cnt_q == CNT_RISE) begin
            phi2_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            phi2_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            phi2_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            phi2_q <= phi2_d;
        end
    end

    assign phi2          = phi2_q;
    assign rise_strobe   = (cnt_q == CNT_RISE);
    assign fall_strobe   = (cnt_q == CNT_LAST);
    // The last high clk is also the one that ends the cycle, so read data lands with the fall.
    assign sample_strobe = (cnt_q == CNT_LAST);

endmodule

// File: rtl/vga_bus_master.sv
// rtl/vga_bus_master.sv - command-driven 6502-style register bus initiator for the VGA card
// Define POLL_TIMEOUT_EN to abandon status polling after POLL_LIMIT busy reads.
module vga_bus_master
    import vga_bus_pkg::*;
#(
    parameter int PHI2_HALF  = 12,
    parameter int POLL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_kind,
    input  logic [7:0]  cmd_instr,
    input  logic [87:0] cmd_args,
    input  logic [3:0]  cmd_nargs,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_result0,
    output logic [7:0]  rsp_result1,
    output logic [3:0]  rsp_status,
    output logic        phi2,
    output logic [3:0]  addr,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in,
    output logic        rw,
    output logic        ce0,
    output logic        ce1b
);
    if (PHI2_HALF < 2 || POLL_LIMIT < 1) begin : g_param_check
        $error("vga_bus_master: PHI2_HALF must be >= 2 and POLL_LIMIT >= 1");
    end

    logic rise_strobe, fall_strobe, sample_strobe;

    phi2_gen #(.PHI2_HALF(PHI2_HALF)) u_phi2_gen (
        .clk          (clk),
        .reset        (reset),
        .phi2         (phi2),
        .rise_strobe  (rise_strobe),
        .fall_strobe  (fall_strobe),
        .sample_strobe(sample_strobe)
    );

    state_t        state_q, state_d;
    logic          active_q, active_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic [7:0]    instr_q, instr_d;
    logic [87:0]   args_q, args_d;
    logic [3:0]    nargs_q, nargs_d;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    addr_q, addr_d;
    logic          rw_q, rw_d;
    logic          ce0_q, ce0_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          data_oe_q, data_oe_d;
    logic [3:0]    rsp_status_q, rsp_status_d;
    logic [7:0]    result0_q, result0_d;
    logic [7:0]    result1_q, result1_d;
`ifdef POLL_TIMEOUT_EN
    localparam int PCW = $clog2(POLL_LIMIT + 1);
    logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
`endif

    logic [7:0] arg_byte;
    assign arg_byte = args_q[{idx_q, 3'b000} +: 8];

    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        instr_d      = instr_q;
        args_d       = args_q;
        nargs_d      = nargs_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        rw_d         = rw_q;
        ce0_d        = ce0_q;
        data_out_d   = data_out_q;
        data_oe_d    = data_oe_q;
        rsp_status_d = rsp_status_q;
        result0_d    = result0_q;
        result1_d    = result1_q;
`ifdef POLL_TIMEOUT_EN
        poll_cnt_d   = poll_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    instr_d      = cmd_instr;
                    args_d       = cmd_args;
                    nargs_d      = cmd_nargs;
                    idx_d        = '0;
                    rsp_status_d = '0;
                    result0_d    = '0;
                    result1_d    = '0;
                    case (cmd_kind)
                        CMD_MODE:  state_d = S_MODE;
                        CMD_INSTR: begin
                            if (cmd_nargs > MAX_NARGS) begin
                                state_d                  = S_RESP;
                                rsp_status_d[STAT_FAULT] = 1'b1;
                            end else if (cmd_nargs == 4'd0) begin
                                state_d = S_INSTR;
                            end else begin
                                state_d = S_ARG;
                            end
                        end
                    endcase
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // Close the running bus cycle; read data is valid on this same clk.
        if (sample_strobe && active_q) begin
            case (state_q)
                S_MODE:  state_d = S_RESP;
                S_ARG: begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q + 1'b1 == nargs_q) begin
                        state_d = S_INSTR;
                    end
                end
                S_INSTR: begin
                    state_d = S_POLL;
`ifdef POLL_TIMEOUT_EN
                    poll_cnt_d = '0;
`endif
                end
                S_POLL: begin
                    rsp_status_d = {1'b0, data_in[STAT_ERROR], data_in[STAT_FINISHED], data_in[STAT_BUSY]};
                    if (!data_in[STAT_BUSY]) begin
                        state_d = S_RD0;
                    end
`ifdef POLL_TIMEOUT_EN
                    else if (poll_cnt_q == PCW'(POLL_LIMIT - 1)) begin
                        state_d                  = S_RESP;
                        rsp_status_d[STAT_FAULT] = 1'b1;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 1'b1;
                    end
`endif
                end
                S_RD0: begin
                    result0_d = data_in;
                    state_d   = S_RD1;
                end
                S_RD1: begin
                    result1_d = data_in;
                    state_d   = S_RESP;
                end
                default: ;
            endcase
        end

        // A command accepted on a falling-edge clk waits for the following fall.
        if (fall_strobe && state_q != S_IDLE) begin
            data_oe_d  = 1'b0;
            data_out_d = '0;
            if (is_bus_state(state_d)) begin
                active_d = 1'b1;
                ce0_d    = 1'b1;
                rw_d     = is_read_state(state_d);
                case (state_d)
                    S_MODE:  addr_d = REG_MODE;
                    S_ARG:   addr_d = REG_ARG0 + idx_d;
                    S_INSTR: addr_d = REG_INSTR;
                    S_POLL:  addr_d = REG_STATUS;
                    S_RD0:   addr_d = REG_RESULT0;
                    S_RD1:   addr_d = REG_RESULT1;
                    default: addr_d = addr_q;
                endcase
            end else begin
                active_d = 1'b0;
                ce0_d    = 1'b0;
                rw_d     = 1'b1;
            end
        end

        if (rise_strobe && active_q && !rw_q) begin
            data_oe_d  = 1'b1;
            data_out_d = (state_q == S_ARG) ? arg_byte : instr_q;
        end

        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            active_q     <= 1'b0;
            cmd_ready_q  <= 1'b0;
            instr_q      <= '0;
            args_q       <= '0;
            nargs_q      <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            rw_q         <= 1'b1;
            ce0_q        <= 1'b0;
            data_out_q   <= '0;
            data_oe_q    <= 1'b0;
            rsp_status_q <= '0;
            result0_q    <= '0;
            result1_q    <= '0;
`ifdef POLL_TIMEOUT_EN
            poll_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            cmd_ready_q  <= cmd_ready_d;
            instr_q      <= instr_d;
            args_q       <= args_d;
            nargs_q      <= nargs_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            ce0_q        <= ce0_d;
            data_out_q   <= data_out_d;
            data_oe_q    <= data_oe_d;
            rsp_status_q <= rsp_status_d;
            result0_q    <= result0_d;
            result1_q    <= result1_d;
`ifdef POLL_TIMEOUT_EN
            poll_cnt_q   <= poll_cnt_d;
`endif
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_status  = rsp_status_q;
    assign rsp_result0 = result0_q;
    assign rsp_result1 = result1_q;
    assign addr        = addr_q;
    assign rw          = rw_q;
    assign ce0         = ce0_q;
    assign ce1b        = ~ce0_q;
    assign data_out    = data_out_q;
    assign data_oe     = data_oe_q;

endmodule

// File: doc/vga_bus_master.md
Name: vga_bus_master

Overview:
- Initiator side of the VGA card's 6502-style register bus: accepts high-level commands and generates PHI2-timed bus cycles (addr/data/rw/ce0/ce1b).
- An instruction command writes its args, writes the instruction, polls status until not busy, then reads both result registers.
- Used as the bring-up/test host and FPGA-side bridge in place of a real 6502. Tri-state is split into data_out/data_oe/data_in; the top level builds the inout.

Parameters:
- PHI2_HALF, 12, clk cycles per PHI2 half-period (~1.05 MHz PHI2 at 25.175 MHz); legal range ≥2.
- POLL_LIMIT, 1024, maximum status reads before timeout fault.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  master idle, accepts command
- cmd_kind  in  1  0=instruction command, 1=mode write
- cmd_instr  in  8  instruction code, or mode byte when cmd_kind=1
- cmd_args  in  88  arg0 in [7:0] … arg10 in [87:80]
- cmd_nargs  in  4  arg count 0..11
- rsp_valid  out  1  response held until accepted
- rsp_ready  in  1  response consumer ready
- rsp_result0  out  8  card result register 0
- rsp_result1  out  8  card result register 1
- rsp_status  out  4  [0] busy at last poll, [1] finished, [2] card error, [3] master fault
- phi2  out  1  bus clock, free-running
- addr  out  4  register address
- data_out  out  8  write data
- data_oe  out  1  drive data bus
- data_in  in  8  read data from bus
- rw  out  1  1=read, 0=write
- ce0  out  1  chip enable, active high
- ce1b  out  1  chip enable, active low

Behaviour:
- Register map: 0=mode_control, 1=instruction (write launches), 2..12=arg0..arg10, 13=status {.., error[2], finished[1], busy[0]}, 14=result0, 15=result1.
- Reset values: phi2=0, addr=0, data_out=0, data_oe=0, rw=1, ce0=0, ce1b=1, cmd_ready=0 during reset then 1, rsp_valid=0, rsp_*=0.
- PHI2: counter divides clk. Low phase = PHI2_HALF clks, then high phase = PHI2_HALF clks. Runs continuously from reset release.
- Bus cycle = one PHI2 period starting at the falling edge.
  - addr, rw, ce0=1, ce1b=0 update on the clk where phi2 falls and hold for the full period.
  - Writes: data_oe=1 and data_out valid from the phi2 rising edge until the next falling edge.
  - Reads: data_in is sampled on the last clk of the high phase.
  - Idle periods: ce0=0, ce1b=1, rw=1, data_oe=0.
- Accepting a command: cmd_valid & cmd_ready, only in IDLE. cmd_ready deasserts the next clk. The first bus cycle starts at the next phi2 falling edge.
- FSM: IDLE → (kind=1) MODE → RESP.
- FSM: IDLE → (kind=0) ARG ×nargs (addr 2..2+n-1, ascending) → INSTR (addr 1) → POLL (addr 13, repeat while busy=1) → RD0 (14) → RD1 (15) → RESP.
- nargs=0 goes straight to INSTR.
- nargs 12..15: no bus cycles; RESP with status=4'b1000, results 0.
- POLL: status is read on every bus cycle. Exit on busy=0, whether or not finished=1. Result registers are always read after exit.
- Mode write response: status=0, results 0.
- RESP: rsp_valid=1 with fields stable until rsp_valid & rsp_ready, then IDLE and cmd_ready=1. A new command and a response handshake can occur on the same clk only after the return to IDLE, so no overlap.
- Latency (instruction, one poll): (nargs+4) PHI2 periods plus alignment up to one period.
- Reset mid-operation: immediate return to reset values. The in-flight command and its response are discarded.

Optional Feature:
- POLL_TIMEOUT_EN defined: poll counter, 0..POLL_LIMIT. After POLL_LIMIT reads with busy=1, skip RD0/RD1 and enter RESP with status={1'b1,last error,last finished,1'b1} and results 0.
- Undefined: poll indefinitely; status[3] is set only for bad nargs.

Decomposition:
- Package vga_bus_pkg: register address constants (REG_MODE…REG_RESULT1), status bit indices, FSM state enum, cmd_kind encodings.
- Sub-module phi2_gen: divider producing phi2, fall_strobe, and sample_strobe (last clk of high phase), one clk wide.

Test Plan:
- Mode write 0x03 → exactly one write cycle addr=0, data_out=0x03 during phi2 high; rsp status=0.
- Instruction 0x01, nargs=3, args 0x41,0x1F,0x05; model busy for 2 polls then finished → writes to addr 2,3,4 then 1=0x01; 3 reads of addr 13; reads of 14,15; rsp_result0/1 match model.
- nargs=13 → no ce0 activity; rsp_status=4'b1000 within 2 clks.
- With POLL_TIMEOUT_EN, POLL_LIMIT=4, busy stuck → 4 status reads, no read of addr 14; rsp_status=4'b1001.
- Assert reset mid-ARG → bus outputs at reset values on the same clk; after release, a new command completes normally.
- Hold rsp_ready=0 for 50 clks → rsp fields stable, cmd_ready=0, no bus activity.
